// File: rtl/dsp_boot_sequencer.sv
// Boot sequencer for the two BF561 DSPs on the DSP_cPCI board.
// Both DSPs are held in reset while a stable BMODE strap is driven. Reset is
// then released, the sequencer waits for both boot-done GPIOs, and it retries
// on timeout. The final READY or FAIL status goes to the board controller.
// DSP0 and DSP1 share one reset and one strap, so their outputs are identical.
module dsp_boot_sequencer #(
    parameter int unsigned RESET_HOLD_CYCLES   = 1000,
    parameter int unsigned BOOT_TIMEOUT_CYCLES = 5000000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_WIDTH           = 24,
    parameter bit          AUTO_START          = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [1:0] BMODE_SEL,
    input  logic       DSP0_BOOT_DONE,
    input  logic       DSP1_BOOT_DONE,
    output logic       DSP0_RESETn,
    output logic       DSP1_RESETn,
    output logic [1:0] DSP0_BMODE,
    output logic [1:0] DSP1_BMODE,
    output logic       BUSY,
    output logic       READY,
    output logic       FAIL,
    output logic [1:0] RETRY_COUNT
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(RESET_HOLD_CYCLES - 32'd1);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST  = CNT_WIDTH'(BOOT_TIMEOUT_CYCLES - 32'd1);
    localparam logic [1:0]           RETRY_MAX = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ASSERT_RST = 3'd1,
        ST_WAIT_BOOT  = 3'd2,
        ST_DONE       = 3'd3,
        ST_FAILED     = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;
    logic [1:0]           retry_r;
    logic [1:0]           retry_nxt_s;
    logic [1:0]           bmode_r;
    logic [1:0]           bmode_nxt_s;
    logic                 resetn_r;
    logic                 resetn_nxt_s;
    logic                 busy_r;
    logic                 busy_nxt_s;
    logic                 ready_r;
    logic                 ready_nxt_s;
    logic                 fail_r;
    logic                 fail_nxt_s;
    logic [1:0]           sync0_r;
    logic [1:0]           sync1_r;
    logic                 auto_pend_r;
    logic                 start_evt_s;
    logic                 done_ok_s;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    // Bring the asynchronous boot-done GPIOs into CLK through two flops each.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync0_r <= 2'b00;
            sync1_r <= 2'b00;
        end else begin
            sync0_r <= {sync0_r[0], DSP0_BOOT_DONE};
            sync1_r <= {sync1_r[0], DSP1_BOOT_DONE};
        end
    end

    assign done_ok_s = sync0_r[1] & sync1_r[1];

    // Mark the first cycle after reset release so that auto-start fires once.
    always_ff @(posedge CLK) begin
        if (RST) begin
            auto_pend_r <= AUTO_START;
        end else begin
            auto_pend_r <= 1'b0;
        end
    end

    // Decide whether a start event happens: START only in the idle states, or the auto-start pulse.
    always_comb begin
        start_evt_s = 1'b0;
        case (state_r)
            ST_IDLE:   start_evt_s = START | auto_pend_r;
            ST_DONE:   start_evt_s = START;
            ST_FAILED: start_evt_s = START;
            default:   start_evt_s = 1'b0;
        endcase
    end

    // Compute next state, counter, retry count and latched strap.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        retry_nxt_s = retry_r;
        bmode_nxt_s = bmode_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_FAILED: begin
                if (start_evt_s) begin
                    state_nxt_s = ST_ASSERT_RST;
                    cnt_nxt_s   = CNT_ZERO;
                    retry_nxt_s = 2'b00;
                    bmode_nxt_s = BMODE_SEL;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_ASSERT_RST: begin
                if (cnt_r >= HOLD_LAST) begin
                    state_nxt_s = ST_WAIT_BOOT;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end
            end
            ST_WAIT_BOOT: begin
                if (done_ok_s) begin
                    state_nxt_s = ST_DONE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r >= TMO_LAST) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (retry_r < RETRY_MAX) begin
                        retry_nxt_s = retry_r + 2'b01;
                        state_nxt_s = ST_ASSERT_RST;
                    end else begin
                        state_nxt_s = ST_FAILED;
                    end
                end else begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Decode the outputs from the next state so that the registered outputs line up with state_r.
    always_comb begin
        resetn_nxt_s = 1'b0;
        busy_nxt_s   = 1'b0;
        ready_nxt_s  = 1'b0;
        fail_nxt_s   = 1'b0;
        case (state_nxt_s)
            ST_ASSERT_RST: busy_nxt_s = 1'b1;
            ST_WAIT_BOOT: begin
                busy_nxt_s   = 1'b1;
                resetn_nxt_s = 1'b1;
            end
            ST_DONE: begin
                ready_nxt_s  = 1'b1;
                resetn_nxt_s = 1'b1;
            end
            ST_FAILED: fail_nxt_s = 1'b1;
            default:   resetn_nxt_s = 1'b0;
        endcase
    end

    // State, counter and registered outputs; RST parks the DSPs in reset with the SPI-master strap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            retry_r  <= 2'b00;
            bmode_r  <= 2'b11;
            resetn_r <= 1'b0;
            busy_r   <= 1'b0;
            ready_r  <= 1'b0;
            fail_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            retry_r  <= retry_nxt_s;
            bmode_r  <= bmode_nxt_s;
            resetn_r <= resetn_nxt_s;
            busy_r   <= busy_nxt_s;
            ready_r  <= ready_nxt_s;
            fail_r   <= fail_nxt_s;
        end
    end

    assign DSP0_RESETn = resetn_r;
    assign DSP1_RESETn = resetn_r;
    assign DSP0_BMODE  = bmode_r;
    assign DSP1_BMODE  = bmode_r;
    assign BUSY        = busy_r;
    assign READY       = ready_r;
    assign FAIL        = fail_r;
    assign RETRY_COUNT = retry_r;

endmodule

// File: tb/tb_dsp_boot_sequencer.sv
// Directed bench for dsp_boot_sequencer with short hold and timeout windows.
module tb_dsp_boot_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [1:0] BMODE_SEL;
    logic       DSP0_BOOT_DONE;
    logic       DSP1_BOOT_DONE;
    logic       DSP0_RESETn;
    logic       DSP1_RESETn;
    logic [1:0] DSP0_BMODE;
    logic [1:0] DSP1_BMODE;
    logic       BUSY;
    logic       READY;
    logic       FAIL;
    logic [1:0] RETRY_COUNT;

    int n_cmp = 0;
    int n_err = 0;

    dsp_boot_sequencer #(
        .RESET_HOLD_CYCLES   (8),
        .BOOT_TIMEOUT_CYCLES (20),
        .MAX_RETRIES         (2),
        .CNT_WIDTH           (24),
        .AUTO_START          (1'b1)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .START          (START),
        .BMODE_SEL      (BMODE_SEL),
        .DSP0_BOOT_DONE (DSP0_BOOT_DONE),
        .DSP1_BOOT_DONE (DSP1_BOOT_DONE),
        .DSP0_RESETn    (DSP0_RESETn),
        .DSP1_RESETn    (DSP1_RESETn),
        .DSP0_BMODE     (DSP0_BMODE),
        .DSP1_BMODE     (DSP1_BMODE),
        .BUSY           (BUSY),
        .READY          (READY),
        .FAIL           (FAIL),
        .RETRY_COUNT    (RETRY_COUNT)
    );

    // Free-running 100 MHz clock.
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Count cycles with reset held low, from the current cycle, checking strap and flags each cycle.
    task automatic measure_low(input logic [1:0] exp_bm, output int n, output bit ok);
        n  = 0;
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (DSP0_RESETn !== 1'b0) break;
            n++;
            if (DSP0_BMODE !== exp_bm || DSP1_BMODE !== exp_bm || DSP1_RESETn !== DSP0_RESETn ||
                BUSY !== 1'b1 || READY !== 1'b0 || FAIL !== 1'b0) ok = 1'b0;
            step();
        end
    endtask

    // Count cycles in the boot wait window (reset released, busy).
    task automatic measure_high(output int n, output bit ok);
        n  = 0;
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (DSP0_RESETn !== 1'b1 || BUSY !== 1'b1) break;
            n++;
            if (DSP1_RESETn !== 1'b1 || READY !== 1'b0 || FAIL !== 1'b0 || DSP1_BMODE !== DSP0_BMODE) ok = 1'b0;
            step();
        end
    endtask

    task automatic pulse_start();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    // Bound the whole run in case the design stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        int n;
        bit ok;
        RST = 1'b1;
        START = 1'b0;
        BMODE_SEL = 2'b11;
        DSP0_BOOT_DONE = 1'b0;
        DSP1_BOOT_DONE = 1'b0;
        repeat (3) step();

        // Reset state
        check_eq("rst_resetn0", {31'd0, DSP0_RESETn}, 32'd0);
        check_eq("rst_resetn1", {31'd0, DSP1_RESETn}, 32'd0);
        check_eq("rst_bmode", {28'd0, DSP1_BMODE, DSP0_BMODE}, 32'hF);
        check_eq("rst_flags", {29'd0, BUSY, READY, FAIL}, 32'd0);
        check_eq("rst_retry", {30'd0, RETRY_COUNT}, 32'd0);

        // Test 1: auto-start, clean boot
        RST = 1'b0;
        step();
        check_eq("t1_busy", {31'd0, BUSY}, 32'd1);
        measure_low(2'b11, n, ok);
        check_eq("t1_low_len", n, 32'd8);
        check_eq("t1_low_ok", {31'd0, ok}, 32'd1);
        repeat (4) step();
        DSP0_BOOT_DONE = 1'b1;
        DSP1_BOOT_DONE = 1'b1;
        step();
        check_eq("t1_ready_c1", {31'd0, READY}, 32'd0);
        step();
        check_eq("t1_ready_c2", {31'd0, READY}, 32'd0);
        step();
        check_eq("t1_ready_c3", {29'd0, BUSY, READY, FAIL}, 32'd2);
        check_eq("t1_retry", {30'd0, RETRY_COUNT}, 32'd0);
        check_eq("t1_resetn", {30'd0, DSP1_RESETn, DSP0_RESETn}, 32'd3);

        // Drop of boot-done in DONE is not monitored
        DSP0_BOOT_DONE = 1'b0;
        DSP1_BOOT_DONE = 1'b0;
        repeat (3) step();
        check_eq("t1_ready_hold", {31'd0, READY}, 32'd1);

        // Test 2: no boot-done, retries then FAIL
        pulse_start();
        for (int p = 0; p < 3; p++) begin
            check_eq("t2_retry", {30'd0, RETRY_COUNT}, p);
            measure_low(2'b11, n, ok);
            check_eq("t2_low_len", n, 32'd8);
            check_eq("t2_low_ok", {31'd0, ok}, 32'd1);
            measure_high(n, ok);
            check_eq("t2_wait_len", n, 32'd20);
            check_eq("t2_wait_ok", {31'd0, ok}, 32'd1);
        end
        check_eq("t2_fail_flags", {29'd0, BUSY, READY, FAIL}, 32'd1);
        check_eq("t2_fail_resetn", {30'd0, DSP1_RESETn, DSP0_RESETn}, 32'd0);
        check_eq("t2_fail_retry", {30'd0, RETRY_COUNT}, 32'd2);
        repeat (5) step();
        check_eq("t2_fail_hold", {29'd0, BUSY, READY, FAIL}, 32'd1);

        // Test 3: only DSP0 done, DSP1 arrives during the retry
        DSP0_BOOT_DONE = 1'b1;
        pulse_start();
        check_eq("t3_retry0", {30'd0, RETRY_COUNT}, 32'd0);
        measure_low(2'b11, n, ok);
        check_eq("t3_low_len", n, 32'd8);
        measure_high(n, ok);
        check_eq("t3_wait_len", n, 32'd20);
        check_eq("t3_retry1", {30'd0, RETRY_COUNT}, 32'd1);
        DSP1_BOOT_DONE = 1'b1;
        measure_low(2'b11, n, ok);
        check_eq("t3_low2_len", n, 32'd8);
        step();
        check_eq("t3_ready", {29'd0, BUSY, READY, FAIL}, 32'd2);
        check_eq("t3_retry_final", {30'd0, RETRY_COUNT}, 32'd1);

        // Test 4: DONE_OK lands on the timeout cycle
        DSP0_BOOT_DONE = 1'b0;
        DSP1_BOOT_DONE = 1'b0;
        pulse_start();
        measure_low(2'b11, n, ok);
        check_eq("t4_low_len", n, 32'd8);
        repeat (17) step();
        DSP0_BOOT_DONE = 1'b1;
        DSP1_BOOT_DONE = 1'b1;
        repeat (2) step();
        check_eq("t4_last_wait", {29'd0, BUSY, READY, FAIL}, 32'd4);
        step();
        check_eq("t4_done", {29'd0, BUSY, READY, FAIL}, 32'd2);
        check_eq("t4_retry", {30'd0, RETRY_COUNT}, 32'd0);
        check_eq("t4_resetn", {31'd0, DSP0_RESETn}, 32'd1);

        // Test 5: RST during WAIT_BOOT at count 10, after one retry
        DSP0_BOOT_DONE = 1'b0;
        DSP1_BOOT_DONE = 1'b0;
        pulse_start();
        measure_low(2'b11, n, ok);
        measure_high(n, ok);
        check_eq("t5_retry1", {30'd0, RETRY_COUNT}, 32'd1);
        measure_low(2'b11, n, ok);
        repeat (10) step();
        check_eq("t5_pre_rst", {31'd0, DSP0_RESETn}, 32'd1);
        BMODE_SEL = 2'b10;
        RST = 1'b1;
        step();
        check_eq("t5_rst_resetn", {30'd0, DSP1_RESETn, DSP0_RESETn}, 32'd0);
        check_eq("t5_rst_flags", {29'd0, BUSY, READY, FAIL}, 32'd0);
        check_eq("t5_rst_retry", {30'd0, RETRY_COUNT}, 32'd0);
        check_eq("t5_rst_bmode", {30'd0, DSP0_BMODE}, 32'd3);
        RST = 1'b0;
        step();
        check_eq("t5_restart_busy", {31'd0, BUSY}, 32'd1);
        DSP0_BOOT_DONE = 1'b1;
        DSP1_BOOT_DONE = 1'b1;
        measure_low(2'b10, n, ok);
        check_eq("t5_low_len", n, 32'd8);
        check_eq("t5_low_ok", {31'd0, ok}, 32'd1);
        step();
        check_eq("t5_ready", {29'd0, BUSY, READY, FAIL}, 32'd2);

        // Test 6: restart from DONE with a new strap; START during BUSY ignored
        BMODE_SEL = 2'b01;
        START = 1'b1;
        step();
        check_eq("t6_bmode", {28'd0, DSP1_BMODE, DSP0_BMODE}, 32'h5);
        check_eq("t6_resetn", {31'd0, DSP0_RESETn}, 32'd0);
        BMODE_SEL = 2'b10;
        measure_low(2'b01, n, ok);
        check_eq("t6_low_len", n, 32'd8);
        check_eq("t6_low_ok", {31'd0, ok}, 32'd1);
        START = 1'b0;
        check_eq("t6_wait_bmode", {30'd0, DSP0_BMODE}, 32'd1);
        step();
        check_eq("t6_ready", {29'd0, BUSY, READY, FAIL}, 32'd2);
        check_eq("t6_ready_bmode", {30'd0, DSP0_BMODE}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
